ysyx_22050710_sram_responder: RTL and testbench

//   Responder (slave) end of the SRAM-like req/addr_ok/data_ok interface driven by the core's inst and data ports.

---
 rtl/ysyx_22050710_sram_responder_pkg.sv | 36 +++
 rtl/ysyx_22050710_sram_resp_fifo.sv | 114 +++++++++++
 rtl/ysyx_22050710_sram_responder.sv | 175 +++++++++++++++++
 tb/tb_ysyx_22050710_sram_responder.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22050710_sram_responder_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_22050710_sram_responder_pkg
//   Shared definitions for the SRAM-like responder: default bus widths, the
//   default memory base address, request size/op encodings and the LFSR step
//   used to generate pseudo-random addr_ok stalls.
// ----------------------------------------------------------------------------
package ysyx_22050710_sram_responder_pkg;

    // Default bus geometry of the core's SRAM-like ports.
    localparam int unsigned SRAM_ADDR_WD_DEF  = 32;
    localparam int unsigned SRAM_DATA_WD_DEF  = 64;
    localparam int unsigned SRAM_WMASK_WD_DEF = SRAM_DATA_WD_DEF / 8;

    // Byte address of memory word 0.
    localparam logic [31:0] MEM_BASE_DEF = 32'h8000_0000;

    // Request size encoding. The responder does not act on it: the byte
    // strobes alone decide which lanes a write touches.
    typedef enum logic [1:0] {
        SIZE_1B = 2'd0,
        SIZE_2B = 2'd1,
        SIZE_4B = 2'd2,
        SIZE_8B = 2'd3
    } sram_size_e;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } sram_op_e;

    // One step of the 16-bit Fibonacci LFSR x^16 + x^14 + x^13 + x^11 + 1.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

endpackage

// File: rtl/ysyx_22050710_sram_resp_fifo.sv
// ----------------------------------------------------------------------------
// ysyx_22050710_sram_resp_fifo
//   In-order queue of accepted-but-unanswered requests. Each entry carries
//   the response data (read word, or zero for a write) and a countdown that
//   is loaded with LATENCY-1 on push and decremented every cycle. The head
//   retires in the cycle its countdown reads zero; retirement is never
//   back-pressured.
//
// Ports
//   i_clk, i_rst     clock, synchronous active-high reset (flushes queue)
//   i_push           enqueue one entry this cycle (caller guarantees room)
//   i_push_rdata     response data of the entry being pushed
//   o_retire         head entry completes this cycle
//   o_head_rdata     response data of the head entry
//   o_full           DEPTH entries outstanding
//   o_cnt            number of outstanding entries
// ----------------------------------------------------------------------------
module ysyx_22050710_sram_resp_fifo
    import ysyx_22050710_sram_responder_pkg::*;
#(
    parameter int unsigned DATA_WD = SRAM_DATA_WD_DEF,
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned LATENCY = 1,
    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_push,
    input  logic [DATA_WD-1:0] i_push_rdata,
    output logic               o_retire,
    output logic [DATA_WD-1:0] o_head_rdata,
    output logic               o_full,
    output logic [CNT_W-1:0]   o_cnt
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CD_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    logic [DATA_WD-1:0] rdata_q [DEPTH];
    logic [DATA_WD-1:0] rdata_d [DEPTH];
    logic [CD_W-1:0]    cd_q    [DEPTH];
    logic [CD_W-1:0]    cd_d    [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               retire;

    // Pointers wrap at DEPTH, which need not fill the pointer width.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // All entries age at the same rate and were pushed in order, so the
    // head is always the first to reach zero.
    assign retire = (cnt_q != '0) && (cd_q[rd_ptr_q] == '0);

    always_comb begin
        rdata_d  = rdata_q;
        cd_d     = cd_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;

        // Countdowns of free slots may age too; they are reloaded on push.
        for (int i = 0; i < DEPTH; i++) begin
            if (cd_q[i] != '0) begin
                cd_d[i] = cd_q[i] - 1'b1;
            end
        end

        // When full, a push can only happen alongside retire, and then it
        // overwrites the slot that the head is vacating this same cycle.
        if (i_push) begin
            rdata_d[wr_ptr_q] = i_push_rdata;
            cd_d[wr_ptr_q]    = CD_W'(LATENCY - 1);
            wr_ptr_d          = ptr_next(wr_ptr_q);
        end

        if (retire) begin
            rd_ptr_d = ptr_next(rd_ptr_q);
        end

        unique case ({i_push, retire})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cd_q     <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            cd_q     <= cd_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Payload needs no reset: it is only observed through a valid head.
    always_ff @(posedge i_clk) begin
        rdata_q <= rdata_d;
    end

    assign o_retire     = retire;
    assign o_head_rdata = rdata_q[rd_ptr_q];
    assign o_full       = (cnt_q == CNT_W'(DEPTH));
    assign o_cnt        = cnt_q;

endmodule

// File: rtl/ysyx_22050710_sram_responder.sv
// ----------------------------------------------------------------------------
// ysyx_22050710_sram_responder
//   Responder end of the SRAM-like req/addr_ok/data_ok interface. Holds a
//   word-addressed memory, commits writes at their accept edge, samples read
//   data at the accept edge and answers every accepted request, in order,
//   exactly LATENCY cycles later. Optionally throttles addr_ok with an LFSR.
//
// Handshake: a request transfers in a cycle where i_sram_req and
//   o_sram_addr_ok are both high (addr_ok is combinational from req and is
//   never high without it); the master holds req and all request fields
//   stable until that cycle. o_sram_data_ok is a one-cycle completion pulse
//   for the oldest outstanding request and cannot be back-pressured.
//
// Ports
//   i_clk, i_rst     clock, synchronous active-high reset
//   i_sram_req       request valid
//   i_sram_op        1 write, 0 read
//   i_sram_size      transfer size (not acted upon; strobes govern)
//   i_sram_addr      byte address
//   i_sram_wstrb     byte write enables
//   i_sram_wdata     write data, lane-aligned to the word
//   o_sram_addr_ok   request accepted this cycle
//   o_sram_data_ok   oldest request completes this cycle
//   o_sram_rdata     read data (zero for writes), valid with data_ok
//   o_bad_addr       sticky flag: an out-of-range address was accepted
// ----------------------------------------------------------------------------
module ysyx_22050710_sram_responder
    import ysyx_22050710_sram_responder_pkg::*;
#(
    parameter int unsigned             SRAM_ADDR_WD    = SRAM_ADDR_WD_DEF,
    parameter int unsigned             SRAM_DATA_WD    = SRAM_DATA_WD_DEF,
    parameter int unsigned             SRAM_WMASK_WD   = SRAM_WMASK_WD_DEF,
    parameter logic [SRAM_ADDR_WD-1:0] MEM_BASE        = SRAM_ADDR_WD'(MEM_BASE_DEF),
    parameter int unsigned             MEM_WORDS       = 4096,
    parameter int unsigned             LATENCY         = 1,
    parameter int unsigned             MAX_OUTSTANDING = 2,
    parameter bit                      RAND_STALL      = 1'b0,
    parameter logic [15:0]             LFSR_SEED       = 16'hACE1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_sram_req,
    input  logic                     i_sram_op,
    input  logic [1:0]               i_sram_size,
    input  logic [SRAM_ADDR_WD-1:0]  i_sram_addr,
    input  logic [SRAM_WMASK_WD-1:0] i_sram_wstrb,
    input  logic [SRAM_DATA_WD-1:0]  i_sram_wdata,
    output logic                     o_sram_addr_ok,
    output logic                     o_sram_data_ok,
    output logic [SRAM_DATA_WD-1:0]  o_sram_rdata,
    output logic                     o_bad_addr
);

    localparam int unsigned BYTE_SHIFT = $clog2(SRAM_WMASK_WD);
    localparam int unsigned IDX_W      = $clog2(MEM_WORDS);
    localparam int unsigned CNT_W      = $clog2(MAX_OUTSTANDING) + 1;

    // Memory contents survive reset, so the array has no reset branch.
    logic [SRAM_DATA_WD-1:0] mem_q [MEM_WORDS];

    logic [15:0]             lfsr_q, lfsr_d;
    logic                    bad_addr_q, bad_addr_d;

    logic [SRAM_ADDR_WD-1:0] offset;
    logic [SRAM_ADDR_WD-1:0] offset_words;
    logic [IDX_W-1:0]        word_idx;
    logic                    in_range;
    logic                    is_write;
    logic                    stall_ok;
    logic                    accept;
    logic                    mem_we;
    logic [SRAM_DATA_WD-1:0] push_rdata;

    logic                    fifo_retire;
    logic                    fifo_full;
    logic [CNT_W-1:0]        fifo_cnt;
    logic [SRAM_DATA_WD-1:0] head_rdata;

    sram_size_e              size_e;
    logic                    unused_bits;

    // ------------------------------------------------------------------
    // Address decode. The low byte-offset bits fall out of the shift, so
    // any address inside a word selects that whole word. An address below
    // MEM_BASE wraps to a huge offset and is rejected by the first term.
    // ------------------------------------------------------------------
    assign offset       = i_sram_addr - MEM_BASE;
    assign offset_words = offset >> BYTE_SHIFT;
    assign word_idx     = offset_words[IDX_W-1:0];
    assign in_range     = (i_sram_addr >= MEM_BASE) &&
                          (offset_words < SRAM_ADDR_WD'(MEM_WORDS));
    assign is_write     = (i_sram_op == OP_WRITE);

    // ------------------------------------------------------------------
    // Acceptance. A retiring head frees its slot in the same cycle, so a
    // full queue can still take a new request when the head completes.
    // ------------------------------------------------------------------
    assign stall_ok       = !RAND_STALL || lfsr_q[0];
    assign o_sram_addr_ok = i_sram_req && !i_rst && (!fifo_full || fifo_retire) && stall_ok;
    assign accept         = o_sram_addr_ok;
    assign mem_we         = accept && is_write && in_range;

    // Reads capture the whole word now, so a later write cannot change a
    // response already in flight; writes and bad addresses answer zero.
    always_comb begin
        push_rdata = '0;
        if (!is_write && in_range) begin
            push_rdata = mem_q[word_idx];
        end
    end

    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            for (int b = 0; b < SRAM_WMASK_WD; b++) begin
                if (i_sram_wstrb[b]) begin
                    mem_q[word_idx][8*b +: 8] <= i_sram_wdata[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // LFSR stall source and sticky bad-address flag.
    // ------------------------------------------------------------------
    always_comb begin
        lfsr_d     = lfsr_q;
        bad_addr_d = bad_addr_q;
        if (RAND_STALL) begin
            lfsr_d = lfsr_step(lfsr_q);
        end
        if (accept && !in_range) begin
            bad_addr_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            lfsr_q     <= LFSR_SEED;
            bad_addr_q <= 1'b0;
        end else begin
            lfsr_q     <= lfsr_d;
            bad_addr_q <= bad_addr_d;
        end
    end

    // ------------------------------------------------------------------
    // Outstanding-request queue.
    // ------------------------------------------------------------------
    ysyx_22050710_sram_resp_fifo #(
        .DATA_WD (SRAM_DATA_WD),
        .DEPTH   (MAX_OUTSTANDING),
        .LATENCY (LATENCY)
    ) u_fifo (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_push       (accept),
        .i_push_rdata (push_rdata),
        .o_retire     (fifo_retire),
        .o_head_rdata (head_rdata),
        .o_full       (fifo_full),
        .o_cnt        (fifo_cnt)
    );

    // A head that would complete while reset is asserted is being flushed,
    // so it must not be reported.
    assign o_sram_data_ok = fifo_retire && !i_rst;
    assign o_sram_rdata   = o_sram_data_ok ? head_rdata : '0;
    assign o_bad_addr     = bad_addr_q;

    // Size is carried on the bus but the strobes decide the lanes; the
    // occupancy count is not needed here beyond the full flag.
    assign size_e      = sram_size_e'(i_sram_size);
    assign unused_bits = ^{size_e, fifo_cnt};

endmodule

// File: tb/tb_ysyx_22050710_sram_responder.sv
module tb_ysyx_22050710_sram_responder;

    localparam int LAT_A = 3;
    localparam int LAT_B = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_a, req_b;
    logic        op;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [7:0]  wstrb;
    logic [63:0] wdata;

    logic        addr_ok_a, data_ok_a, bad_a;
    logic [63:0] rdata_a;
    logic        addr_ok_b, data_ok_b, bad_b;
    logic [63:0] rdata_b;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Deterministic instance: long latency, shallow queue.
    ysyx_22050710_sram_responder #(
        .LATENCY(LAT_A), .MAX_OUTSTANDING(2), .RAND_STALL(1'b0)
    ) dut_a (
        .i_clk(clk), .i_rst(rst), .i_sram_req(req_a), .i_sram_op(op),
        .i_sram_size(size), .i_sram_addr(addr), .i_sram_wstrb(wstrb),
        .i_sram_wdata(wdata), .o_sram_addr_ok(addr_ok_a),
        .o_sram_data_ok(data_ok_a), .o_sram_rdata(rdata_a), .o_bad_addr(bad_a)
    );

    // Randomly stalling instance.
    ysyx_22050710_sram_responder #(
        .LATENCY(LAT_B), .MAX_OUTSTANDING(4), .RAND_STALL(1'b1)
    ) dut_b (
        .i_clk(clk), .i_rst(rst), .i_sram_req(req_b), .i_sram_op(op),
        .i_sram_size(size), .i_sram_addr(addr), .i_sram_wstrb(wstrb),
        .i_sram_wdata(wdata), .o_sram_addr_ok(addr_ok_b),
        .o_sram_data_ok(data_ok_b), .o_sram_rdata(rdata_b), .o_bad_addr(bad_b)
    );

    // ---------------- scoreboard ----------------
    logic [63:0] exp_q_a[$];
    logic [63:0] exp_q_b[$];
    int          due_q_a[$];
    int          due_q_b[$];

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    logic [63:0] e_a, e_b;
    int          d_a, d_b;

    always @(negedge clk) begin
        check("a_addr_ok_without_req", addr_ok_a & ~req_a, 1'b0);
        check("b_addr_ok_without_req", addr_ok_b & ~req_b, 1'b0);
        if (data_ok_a) begin
            if (exp_q_a.size() == 0) check("a_unexpected_data_ok", 1'b1, 1'b0);
            else begin
                e_a = exp_q_a.pop_front();
                d_a = due_q_a.pop_front();
                check("a_rdata", rdata_a, e_a);
                check("a_latency_cycle", 64'(cyc), 64'(d_a));
            end
        end
        if (data_ok_b) begin
            if (exp_q_b.size() == 0) check("b_unexpected_data_ok", 1'b1, 1'b0);
            else begin
                e_b = exp_q_b.pop_front();
                d_b = due_q_b.pop_front();
                check("b_rdata", rdata_b, e_b);
                check("b_latency_cycle", 64'(cyc), 64'(d_b));
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Entered and left at posedge+1. Holds the request until accepted.
    task automatic issue(input int sel, input logic wr, input logic [31:0] a,
                         input logic [7:0] s, input logic [63:0] d,
                         input logic [63:0] exp, output int stalls,
                         output logic dok_at_acc);
        logic acc;
        acc        = 1'b0;
        stalls     = 0;
        dok_at_acc = 1'b0;
        op    = wr;
        addr  = a;
        wstrb = s;
        wdata = d;
        size  = 2'd3;
        if (sel == 0) req_a = 1'b1;
        else          req_b = 1'b1;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            if ((sel == 0) ? addr_ok_a : addr_ok_b) begin
                acc = 1'b1;
                if (sel == 0) begin
                    exp_q_a.push_back(exp);
                    due_q_a.push_back(cyc + LAT_A);
                    dok_at_acc = data_ok_a;
                end else begin
                    exp_q_b.push_back(exp);
                    due_q_b.push_back(cyc + LAT_B);
                    dok_at_acc = data_ok_b;
                end
            end else begin
                stalls++;
            end
            @(posedge clk);
            #1;
        end
        req_a = 1'b0;
        req_b = 1'b0;
        if (!acc) check("accept_timeout", 1'b0, 1'b1);
    endtask

    task automatic wait_idle(input int sel);
        int n;
        n = 0;
        while (((sel == 0) ? exp_q_a.size() : exp_q_b.size()) != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_outstanding", 64'((sel == 0) ? exp_q_a.size() : exp_q_b.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- directed sequence ----------------
    logic [63:0] mdl [16];
    int          st, st2;
    logic        dok;
    logic        rwr;
    int          ridx;
    logic [7:0]  rs;
    logic [63:0] rd, rexp;

    initial begin
        rst = 1'b1; req_a = 1'b0; req_b = 1'b0;
        op = 1'b0; size = 2'd0; addr = '0; wstrb = '0; wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        // Request during reset must not be accepted.
        req_a = 1'b1; req_b = 1'b1;
        @(negedge clk);
        check("rst_addr_ok_a", addr_ok_a, 1'b0);
        check("rst_addr_ok_b", addr_ok_b, 1'b0);
        check("rst_data_ok_a", data_ok_a, 1'b0);
        check("rst_rdata_a", rdata_a, 64'd0);
        check("rst_bad_a", bad_a, 1'b0);
        check("rst_bad_b", bad_b, 1'b0);
        @(posedge clk);
        #1;
        req_a = 1'b0; req_b = 1'b0; rst = 1'b0;

        repeat (5) begin
            @(negedge clk);
            check("idle_addr_ok_a", addr_ok_a, 1'b0);
            check("idle_data_ok_a", data_ok_a, 1'b0);
            check("idle_rdata_a", rdata_a, 64'd0);
            check("idle_data_ok_b", data_ok_b, 1'b0);
            check("idle_rdata_b", rdata_b, 64'd0);
        end
        @(posedge clk);
        #1;

        // Partial write then read-back; word first cleared.
        issue(0, 1'b1, 32'h8000_0008, 8'hFF, 64'h0, 64'h0, st, dok);
        issue(0, 1'b1, 32'h8000_0008, 8'h0F, 64'h1122_3344_5566_7788, 64'h0, st, dok);
        issue(0, 1'b0, 32'h8000_0008, 8'h00, 64'h0, 64'h0000_0000_5566_7788, st, dok);
        issue(0, 1'b1, 32'h8000_0008, 8'h81, 64'hAB00_0000_0000_00CD, 64'h0, st, dok);
        // Low address bits do not affect word selection.
        issue(0, 1'b0, 32'h8000_000D, 8'h00, 64'h0, 64'hAB00_0000_5566_77CD, st, dok);
        wait_idle(0);

        // Back-to-back reads against a two-deep queue.
        issue(0, 1'b1, 32'h8000_0010, 8'hFF, 64'hAAAA_0000_1111_2222, 64'h0, st, dok);
        issue(0, 1'b1, 32'h8000_0018, 8'hFF, 64'hBBBB_0000_3333_4444, 64'h0, st, dok);
        wait_idle(0);
        issue(0, 1'b0, 32'h8000_0010, 8'h00, 64'h0, 64'hAAAA_0000_1111_2222, st, dok);
        check("b2b_first_stalls", 64'(st), 64'd0);
        issue(0, 1'b0, 32'h8000_0018, 8'h00, 64'h0, 64'hBBBB_0000_3333_4444, st, dok);
        check("b2b_second_stalls", 64'(st), 64'd0);
        issue(0, 1'b0, 32'h8000_0008, 8'h00, 64'h0, 64'hAB00_0000_5566_77CD, st, dok);
        check("b2b_third_stalls", 64'(st), 64'd1);
        check("b2b_third_with_data_ok", dok, 1'b1);
        wait_idle(0);
        check("bad_before", bad_a, 1'b0);

        // Out-of-range accesses and range boundaries.
        issue(0, 1'b0, 32'h7FFF_FFF8, 8'h00, 64'h0, 64'h0, st, dok);
        wait_idle(0);
        check("bad_after_low", bad_a, 1'b1);
        issue(0, 1'b1, 32'h8000_0000, 8'hFF, 64'h0123_4567_89AB_CDEF, 64'h0, st, dok);
        issue(0, 1'b1, 32'h8000_8000, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, st, dok);
        issue(0, 1'b0, 32'h8000_0000, 8'h00, 64'h0, 64'h0123_4567_89AB_CDEF, st, dok);
        issue(0, 1'b1, 32'h8000_7FF8, 8'hFF, 64'h5A5A_A5A5_0F0F_F0F0, 64'h0, st, dok);
        issue(0, 1'b0, 32'h8000_7FF8, 8'h00, 64'h0, 64'h5A5A_A5A5_0F0F_F0F0, st, dok);
        issue(0, 1'b0, 32'h8000_8000, 8'h00, 64'h0, 64'h0, st, dok);
        wait_idle(0);
        repeat (3) begin
            @(negedge clk);
            check("bad_sticky", bad_a, 1'b1);
        end
        @(posedge clk);
        #1;

        // Reset with two requests outstanding.
        issue(0, 1'b0, 32'h8000_0000, 8'h00, 64'h0, 64'h0123_4567_89AB_CDEF, st, dok);
        issue(0, 1'b0, 32'h8000_7FF8, 8'h00, 64'h0, 64'h5A5A_A5A5_0F0F_F0F0, st, dok);
        rst = 1'b1;
        exp_q_a.delete(); due_q_a.delete();
        exp_q_b.delete(); due_q_b.delete();
        @(negedge clk);
        check("midrst_data_ok_in_rst", data_ok_a, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("midrst_no_data_ok", data_ok_a, 1'b0);
            check("midrst_rdata", rdata_a, 64'd0);
            check("midrst_bad_cleared", bad_a, 1'b0);
        end
        @(posedge clk);
        #1;
        issue(0, 1'b0, 32'h8000_0000, 8'h00, 64'h0, 64'h0123_4567_89AB_CDEF, st, dok);
        issue(0, 1'b0, 32'h8000_0010, 8'h00, 64'h0, 64'hAAAA_0000_1111_2222, st2, dok);
        check("midrst_empty_first", 64'(st), 64'd0);
        check("midrst_empty_second", 64'(st2), 64'd0);
        wait_idle(0);

        // Random traffic on the stalling instance against a byte model.
        for (int i = 0; i < 16; i++) begin
            mdl[i] = 64'h0;
            issue(1, 1'b1, 32'h8000_0000 + 32'(i * 8), 8'hFF, 64'h0, 64'h0, st, dok);
        end
        for (int n = 0; n < 1000; n++) begin
            rwr  = 1'($urandom_range(0, 1));
            ridx = int'($urandom_range(0, 15));
            rs   = 8'($urandom_range(0, 255));
            rd   = {$urandom, $urandom};
            if (rwr) begin
                for (int b = 0; b < 8; b++) begin
                    if (rs[b]) mdl[ridx][8*b +: 8] = rd[8*b +: 8];
                end
                rexp = 64'h0;
            end else begin
                rexp = mdl[ridx];
            end
            issue(1, rwr, 32'h8000_0000 + 32'(ridx * 8) + 32'($urandom_range(0, 7)),
                  rs, rd, rexp, st, dok);
            if ($urandom_range(0, 7) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        wait_idle(1);
        check("rand_bad_addr", bad_b, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
